// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: FSM states,
// MDU latency defaults and the per-cycle output priority table.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MEMW = 2'd1, MDUW = 2'd2} state_t;

  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 32;

  typedef enum logic [2:0] {
    PRI_FREEZE = 3'd0,
    PRI_REDIR  = 3'd1,
    PRI_FSTALL = 3'd2,
    PRI_JUMP   = 3'd3,
    PRI_NONE   = 3'd4
  } pri_t;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_flush;
    logic idex_we;
    logic exmem_we;
  } ctl_t;

  function automatic ctl_t ctl_for(pri_t p);
    ctl_t c;
    c = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0,
          idex_flush: 1'b0, idex_we: 1'b1, exmem_we: 1'b1};
    case (p)
      PRI_FREEZE: c = '0;
      PRI_REDIR: begin
        c.ifid_flush = 1'b1;
        c.idex_flush = 1'b1;
      end
      PRI_FSTALL: begin
        c.pc_we      = 1'b0;
        c.ifid_we    = 1'b0;
        c.idex_flush = 1'b1;
      end
      PRI_JUMP: c.ifid_flush = 1'b1;
      default: ;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard inputs from the pipeline and stage controls back to it.
interface pipe_stall_ctrl_if #(parameter int PERF_W = 16);
  logic              ld_use_hazard, branch_taken_ex, jump_id;
  logic              mdu_start_ex, mdu_is_div_ex, hilo_use_id;
  logic              dmem_req_mem, dmem_ready;
  logic              pc_we, ifid_we, ifid_flush, idex_flush, idex_we, exmem_we;
  logic              mdu_busy, mdu_done;
  logic [1:0]        state_o;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output ld_use_hazard, branch_taken_ex, jump_id, mdu_start_ex, mdu_is_div_ex,
           hilo_use_id, dmem_req_mem, dmem_ready,
    input  pc_we, ifid_we, ifid_flush, idex_flush, idex_we, exmem_we,
           mdu_busy, mdu_done, state_o, stall_cycles
  );
  modport slave (
    input  ld_use_hazard, branch_taken_ex, jump_id, mdu_start_ex, mdu_is_div_ex,
           hilo_use_id, dmem_req_mem, dmem_ready,
    output pc_we, ifid_we, ifid_flush, idex_flush, idex_we, exmem_we,
           mdu_busy, mdu_done, state_o, stall_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl_mdu_timer.sv
// Multiply/divide latency countdown; done marks the final busy cycle
// (or the issue cycle itself for a single-cycle latency).
module mdu_timer #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);
  logic [CNT_W-1:0] cnt, ld_val;
  logic             one_cyc;

  assign one_cyc = is_div ? (DIV_LAT == 1) : (MUL_LAT == 1);
  assign ld_val  = is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
  assign done    = busy ? (cnt == '0) : (start && one_cyc);

  // a start while busy is simply not looked at
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end else if (start && !one_cyc) begin
      cnt  <= ld_val;
      busy <= 1'b1;
    end
  end
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer: memory freeze, redirect, front stall and
// jump flush, plus the MDU timer and a saturating stall counter.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 6,
  parameter int PERF_W  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_stall_ctrl_if.slave bus
);
  state_t            st, st_nx;
  pri_t              pri;
  ctl_t              ctl;
  logic              busy, done, start, freeze, fstall;
  logic [PERF_W-1:0] perf;

  assign freeze = (st == RUN  && bus.dmem_req_mem && !bus.dmem_ready) ||
                  (st == MEMW && !bus.dmem_ready);
  assign fstall = bus.ld_use_hazard || (busy && bus.hilo_use_id);

  always_comb begin
    pri = PRI_NONE;
    if      (freeze)              pri = PRI_FREEZE;
    else if (bus.branch_taken_ex) pri = PRI_REDIR;
    else if (fstall)              pri = PRI_FSTALL;
    else if (bus.jump_id)         pri = PRI_JUMP;
  end

  assign ctl   = ctl_for(pri);
  assign start = bus.mdu_start_ex && !busy && ctl.exmem_we;

  mdu_timer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) u_mdu (
    .clk(clk), .rst_n(rst_n), .start(start), .is_div(bus.mdu_is_div_ex),
    .busy(busy), .done(done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= RUN;
    else        st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    case (st)
      RUN: begin
        if (bus.dmem_req_mem && !bus.dmem_ready) st_nx = MEMW;
        else if (busy && bus.hilo_use_id)        st_nx = MDUW;
      end
      MEMW: if (bus.dmem_ready) st_nx = (busy && bus.hilo_use_id) ? MDUW : RUN;
      MDUW: if (done) st_nx = RUN;
      default: st_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       perf <= '0;
    else if (!ctl.pc_we && perf != '1) perf <= perf + 1'b1;
  end

  assign bus.pc_we        = ctl.pc_we;
  assign bus.ifid_we      = ctl.ifid_we;
  assign bus.ifid_flush   = ctl.ifid_flush;
  assign bus.idex_flush   = ctl.idex_flush;
  assign bus.idex_we      = ctl.idex_we;
  assign bus.exmem_we     = ctl.exmem_we;
  assign bus.mdu_busy     = busy;
  assign bus.mdu_done     = done;
  assign bus.state_o      = st;
  assign bus.stall_cycles = perf;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: single-cycle priority table, hand-written
// multi-cycle sequences and a randomized run against a cycle-level model.
module tb_pipe_stall_ctrl;
  localparam int PW  = 4;
  localparam int SAT = (1 << PW) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.PERF_W(PW)) ifc();
  pipe_stall_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6), .PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc)
  );

  int tests = 0, fails = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // enables packed as {pc_we, ifid_we, ifid_flush, idex_flush, idex_we, exmem_we}
  function automatic logic [5:0] en();
    return {ifc.pc_we, ifc.ifid_we, ifc.ifid_flush, ifc.idex_flush, ifc.idex_we, ifc.exmem_we};
  endfunction

  task automatic drive(logic ld, logic br, logic jmp, logic ms, logic md,
                       logic hilo, logic req, logic rdy);
    ifc.ld_use_hazard = ld;  ifc.branch_taken_ex = br; ifc.jump_id = jmp;
    ifc.mdu_start_ex  = ms;  ifc.mdu_is_div_ex   = md; ifc.hilo_use_id = hilo;
    ifc.dmem_req_mem  = req; ifc.dmem_ready      = rdy;
  endtask

  // reference model: st 0/1/2, rem = busy cycles still to come, cnt = stall count
  int m_st, m_rem, m_cnt;
  logic [5:0] e_en;
  logic e_busy, e_done, e_start;

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    m_st = 0; m_rem = 0; m_cnt = 0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic model_eval();
    logic frz;
    e_busy = (m_rem > 0);
    frz = (m_st == 0 && ifc.dmem_req_mem && !ifc.dmem_ready) || (m_st == 1 && !ifc.dmem_ready);
    if (frz)                                             e_en = 6'b000000;
    else if (ifc.branch_taken_ex)                        e_en = 6'b111111;
    else if (ifc.ld_use_hazard || (e_busy && ifc.hilo_use_id)) e_en = 6'b000111;
    else if (ifc.jump_id)                                e_en = 6'b111011;
    else                                                 e_en = 6'b110011;
    e_start = ifc.mdu_start_ex && !e_busy && e_en[0];
    e_done  = (m_rem == 1);
  endtask

  task automatic model_step();
    int lat;
    lat = ifc.mdu_is_div_ex ? 32 : 4;
    if (!e_en[5] && m_cnt < SAT) m_cnt++;
    case (m_st)
      0: if (ifc.dmem_req_mem && !ifc.dmem_ready) m_st = 1;
         else if (e_busy && ifc.hilo_use_id) m_st = 2;
      1: if (ifc.dmem_ready) m_st = (e_busy && ifc.hilo_use_id) ? 2 : 0;
      default: if (e_done) m_st = 0;
    endcase
    if (m_rem > 0) m_rem--;
    else if (e_start) m_rem = lat;
  endtask

  typedef struct {
    logic ld, br, jmp, req, rdy;
    logic [5:0] en;
    logic [1:0] st;
  } vec_t;
  vec_t vt[9];

  int nbusy, nstall, done_at, saw2, sawdone;

  initial begin
    vt[0] = '{0, 0, 0, 0, 0, 6'b110011, 2'd0};
    vt[1] = '{1, 0, 0, 0, 0, 6'b000111, 2'd0};
    vt[2] = '{1, 1, 0, 0, 0, 6'b111111, 2'd0};
    vt[3] = '{0, 0, 1, 0, 0, 6'b111011, 2'd0};
    vt[4] = '{1, 0, 1, 0, 0, 6'b000111, 2'd0};
    vt[5] = '{0, 1, 0, 1, 0, 6'b000000, 2'd1};
    vt[6] = '{0, 1, 0, 1, 1, 6'b111111, 2'd0};
    vt[7] = '{0, 1, 1, 0, 0, 6'b111111, 2'd0};
    vt[8] = '{1, 0, 0, 1, 0, 6'b000000, 2'd1};

    // reset state, observed while reset is held
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_en",    en(), 6'b110011);
    chk("rst_mdu",   {ifc.mdu_busy, ifc.mdu_done}, 2'b00);
    chk("rst_state", ifc.state_o, 2'd0);
    chk("rst_perf",  ifc.stall_cycles, 0);
    do_reset();

    foreach (vt[i]) begin
      do_reset();
      drive(vt[i].ld, vt[i].br, vt[i].jmp, 0, 0, 0, vt[i].req, vt[i].rdy);
      #1 chk($sformatf("vec%0d_en", i), en(), vt[i].en);
      @(posedge clk); #1 chk($sformatf("vec%0d_st", i), ifc.state_o, vt[i].st);
    end

    // single-cycle load-use bubble
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("lu_stall", en(), 6'b000111);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("lu_release", en(), 6'b110011);
    chk("lu_perf", ifc.stall_cycles, 1);

    // branch beats load-use
    do_reset();
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    #1 chk("brlu_en", en(), 6'b111111);
    @(posedge clk); #1 chk("brlu_perf", ifc.stall_cycles, 0);

    // memory wait with a held redirect
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      #1 chk("memw_freeze", en(), 6'b000000);
      @(posedge clk); #1 chk("memw_state", ifc.state_o, 2'd1);
    end
    ifc.dmem_ready = 1'b1;
    #1 chk("memw_redir", en(), 6'b111111);
    @(posedge clk); #1 chk("memw_back", ifc.state_o, 2'd0);
    chk("memw_perf", ifc.stall_cycles, 3);

    // divide, dependent reader arrives one cycle after the divide leaves EX
    do_reset();
    drive(0, 0, 0, 1, 1, 0, 0, 0);
    #1 chk("div_issue_busy", ifc.mdu_busy, 0);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 0, 0);
    nbusy = 0; nstall = 0; done_at = 0; saw2 = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n >= 2) ifc.hilo_use_id = 1'b1;
      #1;
      nbusy += int'(ifc.mdu_busy);
      nstall += int'(!ifc.pc_we);
      if (ifc.mdu_done && done_at == 0) done_at = n;
      if (ifc.state_o == 2'd2) saw2 = 1;
      if (n == 33) chk("div_release", ifc.pc_we, 1);
      @(posedge clk); #1;
    end
    chk("div_busy_cycles", nbusy, 32);
    chk("div_done_at", done_at, 32);
    chk("div_stalls", nstall, 31);
    chk("div_saw_mduw", saw2, 1);
    chk("div_perf_sat", ifc.stall_cycles, SAT);

    // multiply with no dependent reader
    do_reset();
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 0, 0);
    nbusy = 0; nstall = 0;
    for (int n = 0; n < 10; n++) begin
      #1 nbusy += int'(ifc.mdu_busy);
      nstall += int'(!ifc.pc_we);
      @(posedge clk); #1;
    end
    chk("mul_busy_cycles", nbusy, 4);
    chk("mul_stalls", nstall, 0);
    chk("mul_perf", ifc.stall_cycles, 0);

    // asynchronous reset in the middle of a divide
    do_reset();
    drive(0, 0, 0, 1, 1, 0, 0, 0);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 1, 0, 0);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("arst_busy", ifc.mdu_busy, 0);
    chk("arst_state", ifc.state_o, 2'd0);
    chk("arst_perf", ifc.stall_cycles, 0);
    sawdone = 0;
    repeat (3) begin @(posedge clk); #1 sawdone |= int'(ifc.mdu_done); end
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      #1 sawdone |= int'(ifc.mdu_done);
      @(posedge clk); #1;
    end
    chk("arst_no_done", sawdone, 0);

    // randomized run against the model
    m_st = 0; m_rem = 0; m_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) do_reset();
      drive($urandom_range(9) == 0, $urandom_range(9) == 0, $urandom_range(9) == 0,
            $urandom_range(11) == 0, $urandom_range(1) == 1, $urandom_range(2) == 0,
            $urandom_range(6) == 0, $urandom_range(1) == 1);
      #1 model_eval();
      chk($sformatf("rand%0d", i),
          {ifc.stall_cycles, ifc.state_o, ifc.mdu_done, ifc.mdu_busy, en()},
          {PW'(m_cnt), 2'(m_st), e_done, e_busy, e_en});
      @(posedge clk);
      model_step();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Combines four inputs into per-stage write-enable and flush controls:
  - the load-use hazard flag from the ID-stage hazard detector
  - taken branch/jump redirects
  - a multi-cycle multiply/divide unit (MDU) timer
  - data-memory wait states
- Sits beside the pipeline registers and drives PC, IF/ID, ID/EX and EX/MEM enables.

Parameters:
- MUL_LAT, 4, MDU cycles for mult/multu (≥1)
- DIV_LAT, 32, MDU cycles for div/divu (≥1)
- CNT_W, 6, MDU countdown width; must hold max(MUL_LAT, DIV_LAT)-1
- PERF_W, 16, stall performance counter width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- ld_use_hazard  in  1  load-use hazard flag for the instruction in ID
- branch_taken_ex  in  1  branch in EX resolved taken
- jump_id  in  1  j/jal/jr decoded in ID
- mdu_start_ex  in  1  mult/div in EX, valid this cycle
- mdu_is_div_ex  in  1  qualifies mdu_start_ex: 1 = divide
- hilo_use_id  in  1  ID instruction reads HI/LO or is an MDU op
- dmem_req_mem  in  1  MEM stage access in progress
- dmem_ready  in  1  data memory completes access this cycle
- pc_we  out  1  PC update enable
- ifid_we  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID clear to NOP
- idex_flush  out  1  ID/EX clear to NOP (bubble)
- idex_we  out  1  ID/EX register enable
- exmem_we  out  1  EX/MEM register enable
- mdu_busy  out  1  MDU operation in flight
- mdu_done  out  1  one-cycle pulse on the last MDU cycle
- state_o  out  2  FSM state, for debug
- stall_cycles  out  PERF_W  saturating count of cycles with pc_we=0

Behaviour:
Reset (rst_n low, asynchronous):
- FSM to RUN, MDU counter 0, mdu_busy 0, stall_cycles 0.
- Outputs in this state: pc_we=ifid_we=idex_we=exmem_we=1, all flushes 0, mdu_done 0.
- Reset asserted mid-MDU or mid-MEMW aborts immediately; no mdu_done pulse.

FSM states: RUN=0, MEMW=1, MDUW=2.
- RUN→MEMW: dmem_req_mem && !dmem_ready.
- MEMW→RUN or MDUW: on dmem_ready. Goes to MDUW if mdu_busy && hilo_use_id, else RUN.
- RUN→MDUW: mdu_busy && hilo_use_id.
- MDUW→RUN: on mdu_done.
- Registered state. Outputs are combinational from state plus current inputs, with same-cycle effect.

Output rules, applied per cycle; the first matching rule wins:
- 1. Freeze, when (RUN && dmem_req_mem && !dmem_ready) or MEMW && !dmem_ready.
  - All four enables 0, no flushes.
  - branch_taken_ex is held by the frozen EX stage, so the redirect is applied on the release cycle.
- 2. Redirect, when branch_taken_ex.
  - pc_we=1, ifid_flush=1, idex_flush=1.
  - Overrides ld_use_hazard and the MDU stall, because the offending ID instruction is discarded.
- 3. Front stall, when ld_use_hazard, or mdu_busy && hilo_use_id.
  - pc_we=0, ifid_we=0, idex_flush=1; exmem_we stays 1.
  - A load-use stall lasts exactly as long as the input; the detector drops it after one bubble.
- 4. Jump, when jump_id.
  - ifid_flush=1, pc_we=1.
- 5. Otherwise all enables 1 and no flushes.

MDU timer:
- Starts when mdu_start_ex && !mdu_busy && exmem_we.
- Loads DIV_LAT-1 or MUL_LAT-1 and sets mdu_busy. Latency 1 means done in the issue cycle: mdu_done=1, busy never set.
- Decrements every cycle, including during freeze.
- mdu_done=1 on the cycle the count is 0 while busy; busy clears on the next edge.
- mdu_start_ex while busy cannot occur, because ID is stalled by hilo_use_id. If it does occur anyway, it is ignored.

stall_cycles increments on every clock with pc_we=0 and saturates at all-ones.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encodings RUN/MEMW/MDUW
  - MUL_LAT/DIV_LAT defaults
  - the output-priority encoding constants
- One natural sub-module, mdu_timer, owns the countdown, mdu_busy and mdu_done. Its ports: clk, rst_n, start, is_div, busy, done.

Test Plan:
- Load-use: ld_use_hazard=1 for 1 cycle → that cycle pc_we=0, ifid_we=0, idex_flush=1, exmem_we=1; next cycle all enables 1; stall_cycles=1.
- Branch plus load-use in the same cycle → pc_we=1, ifid_flush=1, idex_flush=1, no stall; stall_cycles unchanged.
- Memory wait: dmem_req_mem=1, dmem_ready=0 for 3 cycles, with branch_taken_ex=1 held → enables 0 for 3 cycles and state_o=1. On the dmem_ready cycle, redirect flushes fire and the FSM returns to RUN.
- Divide: mdu_start_ex, mdu_is_div_ex=1, then hilo_use_id=1 → mdu_busy for 32 cycles and mdu_done at cycle 32. Front stall for 31 cycles (state_o=2), release on the cycle after mdu_done.
- Multiply with no dependent instruction → mdu_busy for 4 cycles, zero stalls, pc_we stays 1.
- Reset asserted asynchronously at divide cycle 10 → mdu_busy=0 and state_o=0 immediately, stall_cycles=0, no mdu_done pulse.
